frame_buffer_arbiter: RTL

//  Sole owner of the single-port frameRAM (1-cycle synchronous read). Shares the RAM

---
 rtl/frame_buffer_arbiter_if.sv | 32 +++
 rtl/frame_buffer_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter_if.sv
// Bus between the frame buffer arbiter and its neighbours: VGA scan position,
// clear control, draw-engine write port, frameRAM port and pixel output.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 5
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              vblank;
  logic              clear_req;
  logic              clear_busy;
  logic              wr_req;
  logic [9:0]        wr_x;
  logic [9:0]        wr_y;
  logic [PIX_W-1:0]  wr_pixel;
  logic              wr_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata;
  logic [PIX_W-1:0]  pixel_out;

  modport master (
    output DrawX, DrawY, vblank, clear_req, wr_req, wr_x, wr_y, wr_pixel, ram_rdata,
    input  clear_busy, wr_ack, ram_addr, ram_we, ram_wdata, pixel_out
  );

  modport slave (
    input  DrawX, DrawY, vblank, clear_req, wr_req, wr_x, wr_y, wr_pixel, ram_rdata,
    output clear_busy, wr_ack, ram_addr, ram_we, ram_wdata, pixel_out
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Time-multiplexes the single-port frameRAM between scanout reads (phase 0) and
// draw/clear writes (phase 1, plus phase 0 outside the visible area).
//
// state        | meaning
// S_IDLE       | no clear pending; writer served in write slots
// S_CLEAR_WAIT | clear requested, waiting for vblank; writer still served
// S_CLEARING   | every write slot writes CLEAR_COLOR; writer stalled
module frame_buffer_arbiter #(
  parameter int              H_RES       = 640,
  parameter int              V_RES       = 480,
  parameter int              ADDR_W      = 19,
  parameter int              PIX_W       = 5,
  parameter logic [PIX_W-1:0] TRANSP      = 5'h15,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = 5'h00
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  frame_buffer_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR_WAIT,
    S_CLEARING
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_phase;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic [PIX_W-1:0]  r_pixel;

  logic              w_disp_vis;
  logic              w_wr_vis;
  logic              w_wr_ok;
  logic              w_disp_slot;
  logic              w_write_slot;
  logic [ADDR_W-1:0] w_disp_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [PIX_W-1:0]  w_wdata;
  logic              w_ack;

  // Coordinates are range-checked first; the address product is formed at 32 bits.
  assign w_disp_vis  = (32'(bus.DrawX) < 32'(H_RES)) && (32'(bus.DrawY) < 32'(V_RES));
  assign w_wr_vis    = (32'(bus.wr_x)  < 32'(H_RES)) && (32'(bus.wr_y)  < 32'(V_RES));
  assign w_wr_ok     = w_wr_vis && (bus.wr_pixel != TRANSP);
  assign w_disp_addr = ADDR_W'(32'(bus.DrawX) + 32'(bus.DrawY) * 32'(H_RES));
  assign w_wr_addr   = ADDR_W'(32'(bus.wr_x)  + 32'(bus.wr_y)  * 32'(H_RES));

  assign w_disp_slot  = !r_phase && w_disp_vis;
  assign w_write_slot = !w_disp_slot;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_addr        = '0;
    w_we          = 1'b0;
    w_wdata       = '0;
    w_ack         = 1'b0;

    if (w_disp_slot) begin
      w_addr = w_disp_addr;
    end

    case (r_state)
      S_IDLE: begin
        if (w_write_slot && bus.wr_req) begin
          w_ack = 1'b1;
          if (w_wr_ok) begin
            w_we    = 1'b1;
            w_addr  = w_wr_addr;
            w_wdata = bus.wr_pixel;
          end
        end
        if (bus.clear_req) begin
          w_state_nxt = S_CLEAR_WAIT;
        end
      end
      S_CLEAR_WAIT: begin
        if (w_write_slot && bus.wr_req) begin
          w_ack = 1'b1;
          if (w_wr_ok) begin
            w_we    = 1'b1;
            w_addr  = w_wr_addr;
            w_wdata = bus.wr_pixel;
          end
        end
        if (bus.vblank) begin
          w_state_nxt   = S_CLEARING;
          w_clr_cnt_nxt = '0;
        end
      end
      S_CLEARING: begin
        if (w_write_slot) begin
          w_we          = 1'b1;
          w_addr        = r_clr_cnt;
          w_wdata       = CLEAR_COLOR;
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
          if (r_clr_cnt == LAST_ADDR) begin
            w_state_nxt   = S_IDLE;
            w_clr_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after a display-slot address; capture it then.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_phase      <= 1'b0;
      r_rd_pending <= 1'b0;
      r_pixel      <= '0;
    end else begin
      r_phase      <= !r_phase;
      r_rd_pending <= w_disp_slot;
      if (r_rd_pending) begin
        r_pixel <= bus.ram_rdata;
      end
    end
  end

  // RAM strobes are held inactive for as long as reset is asserted.
  assign bus.ram_addr   = Reset_n ? w_addr  : '0;
  assign bus.ram_we     = Reset_n & w_we;
  assign bus.ram_wdata  = Reset_n ? w_wdata : '0;
  assign bus.wr_ack     = Reset_n & w_ack;
  assign bus.clear_busy = (r_state != S_IDLE);
  assign bus.pixel_out  = r_pixel;

endmodule
